// File: rtl/cordic_phase_feeder.sv
// -----------------------------------------------------------------------------
// cordic_phase_feeder
//
// Front end of the iterative rotation-mode CORDIC used by the function
// generator. A DDS phase accumulator advances once per sample tick. Each tick
// folds the phase into [-pi/2, pi/2] and launches one CORDIC conversion with
// X = amplitude, Y = 0 and Z = folded angle. The result is captured, the
// cosine sign is corrected for the fold, and the sin/cos pair is presented
// to the output stage with a one-cycle valid strobe.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rst_i           synchronous reset, active high
//   en_i            enables sample ticks (and therefore new launches)
//   sync_i          clears phase accumulator and tick counter
//   freq_word_i     phase increment per sample tick
//   phase_ofs_i     phase offset added to the accumulator top 8 bits
//   amp_i           amplitude (pre-scaled by 1/CORDIC gain in software)
//   cordic_strb_o   one-cycle launch strobe to the CORDIC
//   cordic_X_o/Y_o/Z_o  CORDIC operands, held between launches
//   cordic_strb_i   CORDIC done strobe
//   cordic_X_i/Y_i  CORDIC results (cosine / sine)
//   sin_o/cos_o     output samples, held until the next capture
//   sample_valid_o  one-cycle strobe when sin_o/cos_o update
//   overrun_o       sticky: a tick arrived while a conversion was in flight
//   timeout_o       sticky: CORDIC did not answer in time
// -----------------------------------------------------------------------------
module cordic_phase_feeder #(
   parameter int PHASE_W      = 16,
   parameter int SAMPLE_DIV   = 16,
   parameter int PI_HALF_CODE = 101,
   parameter int TIMEOUT      = 31
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                sync_i,
   input  logic [PHASE_W-1:0]  freq_word_i,
   input  logic [7:0]          phase_ofs_i,
   input  logic signed [7:0]   amp_i,
   output logic                cordic_strb_o,
   output logic signed [7:0]   cordic_X_o,
   output logic signed [7:0]   cordic_Y_o,
   output logic signed [7:0]   cordic_Z_o,
   input  logic                cordic_strb_i,
   input  logic signed [7:0]   cordic_X_i,
   input  logic signed [7:0]   cordic_Y_i,
   output logic signed [7:0]   sin_o,
   output logic signed [7:0]   cos_o,
   output logic                sample_valid_o,
   output logic                overrun_o,
   output logic                timeout_o
);

   localparam int CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT);
   localparam logic signed [17:0] PI_HALF_S = 18'(PI_HALF_CODE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_OUT
   } state_t;

   state_t state_reg, state_next;

   logic [CNT_W-1:0]   tick_cnt_reg;
   logic [PHASE_W-1:0] acc_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   logic signed [7:0]  x_reg;
   logic signed [7:0]  z_reg;
   logic               negc_reg;
   logic signed [7:0]  sin_reg;
   logic signed [7:0]  cos_reg;
   logic               overrun_reg;
   logic               timeout_reg;

   logic               tick;
   logic [7:0]         angle_u;
   logic signed [7:0]  angle_s;
   logic signed [8:0]  angle_ext;
   logic signed [8:0]  fold_s;
   logic               fold_negc;
   logic signed [17:0] fold_wide;
   logic signed [17:0] z_wide;
   logic signed [7:0]  z_next;
   logic signed [7:0]  cos_neg;

   logic               launch_load;
   logic               wait_clr;
   logic               capture;
   logic               timeout_set;
   logic               overrun_set;

   // sync_i wins over a tick that would otherwise fire in the same cycle.
   assign tick = en_i && !sync_i && (tick_cnt_reg == CNT_LAST);

   assign angle_u = acc_reg[PHASE_W-1 -: 8] + phase_ofs_i;
   assign angle_s = $signed(angle_u);

   // Reflect angles beyond +/-pi/2 back into range; cos changes sign, sin
   // does not. -128 (= -pi) lands on 0 with the cosine negated.
   always_comb begin
      angle_ext = {angle_s[7], angle_s};
      fold_s    = angle_ext;
      fold_negc = 1'b0;
      if (angle_s > 8'sd64) begin
         fold_s    = 9'sd128 - angle_ext;
         fold_negc = 1'b1;
      end else if (angle_s < -8'sd64) begin
         fold_s    = -9'sd128 - angle_ext;
         fold_negc = 1'b1;
      end
   end

   // Scale pi/128 steps to the CORDIC Q1.6 radian format with rounding.
   always_comb begin
      fold_wide = {{9{fold_s[8]}}, fold_s};
      z_wide    = (fold_wide * PI_HALF_S + 18'sd32) >>> 6;
      z_next    = z_wide[7:0];
   end

   // Negating -128 is the only case that overflows 8 bits.
   assign cos_neg = (cordic_X_i == 8'sh80) ? 8'sd127 : -cordic_X_i;

   assign overrun_set = tick && (state_reg != ST_IDLE);

   always_comb begin
      state_next  = state_reg;
      launch_load = 1'b0;
      wait_clr    = 1'b0;
      capture     = 1'b0;
      timeout_set = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (tick) begin
               launch_load = 1'b1;
               state_next  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wait_clr   = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (cordic_strb_i) begin
               capture    = 1'b1;
               state_next = ST_OUT;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               timeout_set = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         ST_OUT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         tick_cnt_reg <= '0;
         acc_reg      <= '0;
         wait_cnt_reg <= '0;
         x_reg        <= '0;
         z_reg        <= '0;
         negc_reg     <= 1'b0;
         sin_reg      <= '0;
         cos_reg      <= '0;
         overrun_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;

         // The accumulator advances on every tick, including dropped ones,
         // so the output phase stays locked to real time after an overrun.
         if (sync_i) begin
            tick_cnt_reg <= '0;
            acc_reg      <= '0;
         end else begin
            if (en_i) begin
               tick_cnt_reg <= (tick_cnt_reg == CNT_LAST) ? '0
                                                          : tick_cnt_reg + CNT_W'(1);
            end
            if (tick) begin
               acc_reg <= acc_reg + freq_word_i;
            end
         end

         if (launch_load) begin
            x_reg    <= amp_i;
            z_reg    <= z_next;
            negc_reg <= fold_negc;
         end

         if (wait_clr) begin
            wait_cnt_reg <= '0;
         end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end

         if (capture) begin
            sin_reg <= cordic_Y_i;
            cos_reg <= negc_reg ? cos_neg : cordic_X_i;
         end

         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end
         if (timeout_set) begin
            timeout_reg <= 1'b1;
         end
      end
   end

   assign cordic_strb_o  = (state_reg == ST_LAUNCH);
   assign sample_valid_o = (state_reg == ST_OUT);
   assign cordic_X_o     = x_reg;
   assign cordic_Y_o     = 8'sd0;
   assign cordic_Z_o     = z_reg;
   assign sin_o          = sin_reg;
   assign cos_o          = cos_reg;
   assign overrun_o      = overrun_reg;
   assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// -----------------------------------------------------------------------------
// tb_cordic_phase_feeder
//
// Drives cordic_phase_feeder with directed and randomized segments. A CORDIC
// stand-in answers launches after a configurable delay (or never). A monitor
// compares every launch against the phase predicted in closed form from the
// launch index, and every sample against the values the stand-in returned.
// -----------------------------------------------------------------------------
module tb_cordic_phase_feeder;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              en_i;
   logic              sync_i;
   logic [15:0]       freq_word_i;
   logic [7:0]        phase_ofs_i;
   logic signed [7:0] amp_i;
   logic              cordic_strb_o;
   logic signed [7:0] cordic_X_o;
   logic signed [7:0] cordic_Y_o;
   logic signed [7:0] cordic_Z_o;
   logic              cordic_strb_i;
   logic signed [7:0] cordic_X_i;
   logic signed [7:0] cordic_Y_i;
   logic signed [7:0] sin_o;
   logic signed [7:0] cos_o;
   logic              sample_valid_o;
   logic              overrun_o;
   logic              timeout_o;

   always #5 clk = ~clk;

   cordic_phase_feeder dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .sync_i         (sync_i),
      .freq_word_i    (freq_word_i),
      .phase_ofs_i    (phase_ofs_i),
      .amp_i          (amp_i),
      .cordic_strb_o  (cordic_strb_o),
      .cordic_X_o     (cordic_X_o),
      .cordic_Y_o     (cordic_Y_o),
      .cordic_Z_o     (cordic_Z_o),
      .cordic_strb_i  (cordic_strb_i),
      .cordic_X_i     (cordic_X_i),
      .cordic_Y_i     (cordic_Y_i),
      .sin_o          (sin_o),
      .cos_o          (cos_o),
      .sample_valid_o (sample_valid_o),
      .overrun_o      (overrun_o),
      .timeout_o      (timeout_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state for the current segment.
   int m_freq;
   int m_ofs;
   int m_amp;
   int m_tpl;           // sample ticks per launch (2 when every other tick overruns)
   int launch_idx;
   bit exp_negc;
   int exp_sin;
   int exp_cos;

   // CORDIC stand-in controls.
   int resp_mode  = 0;  // 0: answer, 1: never answer
   int resp_delay = 4;
   bit rand_delay = 1'b0;
   bit fixed_resp = 1'b0;
   int fix_x      = 0;
   int fix_y      = 0;
   bit stray_req  = 1'b0;

   // Monitor bookkeeping.
   bit check_period  = 1'b0;
   int last_valid_cyc = -1;
   int valid_count    = 0;
   int strobe_count   = 0;
   bit prev_valid     = 1'b0;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sext8(input int v);
      int u;
      u = v & 255;
      return (u >= 128) ? u - 256 : u;
   endfunction

   // Phase of launch n in units of pi/128, folded into [-pi/2, pi/2].
   function automatic void ref_angle(input int n, input int freq, input int ofs,
                                     input int tpl, output int z, output bit negc);
      longint ph;
      int     s;
      int     sf;
      ph   = (longint'(n) * tpl * freq) % 65536;
      s    = sext8(int'(ph >>> 8) + ofs);
      sf   = s;
      negc = 1'b0;
      if (s > 64) begin
         sf   = 128 - s;
         negc = 1'b1;
      end else if (s < -64) begin
         sf   = -128 - s;
         negc = 1'b1;
      end
      z = (sf * 101 + 32) >>> 6;
   endfunction

   // Monitor: one line per launch and per sample.
   initial begin
      int  z;
      bit  nc;
      forever begin
         @(negedge clk);
         if (cordic_strb_o) begin
            ref_angle(launch_idx, m_freq, m_ofs, m_tpl, z, nc);
            $display("launch %0d: Z=%0d X=%0d Y=%0d (exp Z=%0d negc=%0d)",
                     launch_idx, cordic_Z_o, cordic_X_o, cordic_Y_o, z, nc);
            check_val("launch_Z", int'(cordic_Z_o), z);
            check_val("launch_X", int'(cordic_X_o), sext8(m_amp));
            check_val("launch_Y", int'(cordic_Y_o), 0);
            exp_negc = nc;
            launch_idx++;
            strobe_count++;
         end
         if (sample_valid_o) begin
            $display("sample: sin=%0d cos=%0d (exp sin=%0d cos=%0d)",
                     sin_o, cos_o, exp_sin, exp_cos);
            check_val("valid_width", int'(prev_valid), 0);
            check_val("sample_sin", int'(sin_o), exp_sin);
            check_val("sample_cos", int'(cos_o), exp_cos);
            if (check_period && last_valid_cyc >= 0)
               check_val("sample_period", cyc - last_valid_cyc, 16 * m_tpl);
            last_valid_cyc = cyc;
            valid_count++;
         end
         prev_valid = sample_valid_o;
      end
   end

   // CORDIC stand-in.
   initial begin
      int d;
      int rx;
      int ry;
      cordic_strb_i = 1'b0;
      cordic_X_i    = '0;
      cordic_Y_i    = '0;
      forever begin
         @(negedge clk);
         cordic_strb_i = 1'b0;
         if (stray_req) begin
            cordic_X_i    = 8'sh85;
            cordic_Y_i    = 8'sh85;
            cordic_strb_i = 1'b1;
            stray_req     = 1'b0;
         end else if (cordic_strb_o && resp_mode == 0) begin
            d = rand_delay ? int'($urandom_range(1, 12)) : resp_delay;
            repeat (d) @(negedge clk);
            rx = fixed_resp ? fix_x : sext8(int'($urandom));
            ry = fixed_resp ? fix_y : sext8(int'($urandom));
            exp_sin = ry;
            exp_cos = exp_negc ? ((rx == -128) ? 127 : -rx) : rx;
            cordic_X_i    = 8'(rx);
            cordic_Y_i    = 8'(ry);
            cordic_strb_i = 1'b1;
         end
      end
   end

   task automatic start_seg(input int f, input int o, input int a, input int tpl);
      m_freq         = f;
      m_ofs          = o;
      m_amp          = a;
      m_tpl          = tpl;
      launch_idx     = 0;
      last_valid_cyc = -1;
      freq_word_i    = 16'(f);
      phase_ofs_i    = 8'(o);
      amp_i          = 8'(a);
      sync_i         = 1'b1;
      en_i           = 1'b1;
      @(negedge clk);
      sync_i = 1'b0;
   endtask

   task automatic stop_seg();
      en_i = 1'b0;
      repeat (50) @(negedge clk);
   endtask

   // Bounded waits; each returns one negedge after the event was seen.
   task automatic wait_valid(input string tag, input int max);
      int k;
      k = 0;
      while (!sample_valid_o && k < max) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, int'(sample_valid_o), 1);
      @(negedge clk);
   endtask

   task automatic wait_strobe(input string tag, input int max);
      int k;
      k = 0;
      while (!cordic_strb_o && k < max) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, int'(cordic_strb_o), 1);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_strb"},    int'(cordic_strb_o),  0);
      check_val({tag, "_X"},       int'(cordic_X_o),     0);
      check_val({tag, "_Y"},       int'(cordic_Y_o),     0);
      check_val({tag, "_Z"},       int'(cordic_Z_o),     0);
      check_val({tag, "_sin"},     int'(sin_o),          0);
      check_val({tag, "_cos"},     int'(cos_o),          0);
      check_val({tag, "_valid"},   int'(sample_valid_o), 0);
      check_val({tag, "_overrun"}, int'(overrun_o),      0);
      check_val({tag, "_timeout"}, int'(timeout_o),      0);
   endtask

   initial begin
      int vc;
      int sc;
      int s0;
      int c0;
      rst_i       = 1'b1;
      en_i        = 1'b0;
      sync_i      = 1'b0;
      freq_word_i = '0;
      phase_ofs_i = '0;
      amp_i       = '0;
      m_freq = 0; m_ofs = 0; m_amp = 0; m_tpl = 1; launch_idx = 0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_i = 1'b0;
      @(negedge clk);

      // No fold: s = 64 -> Z = 101.
      fixed_resp = 1'b1; fix_x = 3; fix_y = 77; resp_delay = 3;
      start_seg(0, 8'h40, 8'h50, 1);
      wait_strobe("t2_strobe", 40);
      check_val("t2_Z", int'(cordic_Z_o), 101);
      check_val("t2_X", int'(cordic_X_o), 80);
      check_val("t2_Y", int'(cordic_Y_o), 0);
      wait_valid("t2_valid", 40);
      check_val("t2_cos", int'(cos_o), 3);
      check_val("t2_sin", int'(sin_o), 77);
      check_val("t2_valid_low", int'(sample_valid_o), 0);
      stop_seg();

      // Fold above pi/2.
      fix_x = 40; fix_y = 10;
      start_seg(0, 8'h60, 8'h30, 1);
      wait_strobe("t3a_strobe", 40);
      check_val("t3a_Z", int'(cordic_Z_o), 51);
      wait_valid("t3a_valid", 40);
      check_val("t3a_cos", int'(cos_o), -40);
      stop_seg();

      // Fold below -pi/2 with the saturating negation.
      fix_x = -128; fix_y = 5;
      start_seg(0, 8'hA0, 8'h30, 1);
      wait_strobe("t3b_strobe", 40);
      check_val("t3b_Z", int'(cordic_Z_o), -50);
      wait_valid("t3b_valid", 40);
      check_val("t3b_cos", int'(cos_o), 127);
      stop_seg();

      // s = -128: folds to 0 with cosine negated.
      fix_x = 20; fix_y = -3;
      start_seg(0, 8'h80, 8'h30, 1);
      wait_strobe("t3c_strobe", 40);
      check_val("t3c_Z", int'(cordic_Z_o), 0);
      wait_valid("t3c_valid", 40);
      check_val("t3c_cos", int'(cos_o), -20);
      stop_seg();

      // Randomized segments with random CORDIC latency.
      fixed_resp = 1'b0; rand_delay = 1'b1;
      for (int seg = 0; seg < 3; seg++) begin
         start_seg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1);
         for (int i = 0; i < 40; i++) wait_valid("rand_valid", 40);
         stop_seg();
      end

      // Rate: one sample per 16 cycles, phase steps by 1, full wrap.
      rand_delay = 1'b0; resp_delay = 4; check_period = 1'b1;
      start_seg(16'h0100, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
      for (int i = 0; i < 260; i++) wait_valid("t4_valid", 40);
      check_period = 1'b0;
      check_val("t4_overrun", int'(overrun_o), 0);
      check_val("t4_timeout", int'(timeout_o), 0);
      stop_seg();

      // en_i dropped mid-conversion: sample still emitted, no new launches.
      resp_delay = 8;
      start_seg(int'($urandom_range(1, 65535)), int'($urandom_range(0, 255)), 8'h55, 1);
      wait_strobe("t6_en_strobe", 40);
      en_i = 1'b0;
      wait_valid("t6_en_valid", 30);
      sc = strobe_count;
      repeat (60) @(negedge clk);
      check_val("t6_no_relaunch", strobe_count - sc, 0);
      stop_seg();

      // sync_i mid-conversion: not aborted, next launch restarts at phase_ofs.
      rand_delay = 1'b1;
      start_seg(int'($urandom_range(1, 65535)), int'($urandom_range(0, 255)), 8'h21, 1);
      for (int i = 0; i < 3; i++) wait_valid("t6_sync_pre", 40);
      wait_strobe("t6_sync_strobe", 40);
      sync_i = 1'b1;
      launch_idx = 0;
      @(negedge clk);
      sync_i = 1'b0;
      wait_valid("t6_sync_valid", 30);
      wait_strobe("t6_sync_relaunch", 40);
      stop_seg();

      // Done strobe outside WAIT is ignored.
      vc = valid_count; s0 = int'(sin_o); c0 = int'(cos_o);
      stray_req = 1'b1;
      repeat (8) @(negedge clk);
      check_val("stray_valid", valid_count - vc, 0);
      check_val("stray_sin", int'(sin_o), s0);
      check_val("stray_cos", int'(cos_o), c0);

      // Overrun: CORDIC slower than the sample period, every other tick dropped.
      rand_delay = 1'b0; resp_delay = 20;
      start_seg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 2);
      for (int i = 0; i < 5; i++) wait_valid("t5_ovr_valid", 60);
      check_val("t5_overrun", int'(overrun_o), 1);
      check_val("t5_no_timeout", int'(timeout_o), 0);
      stop_seg();

      // Timeout: CORDIC never answers.
      resp_mode = 1;
      vc = valid_count;
      start_seg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)), 8'h11, 1);
      wait_strobe("t5_to_strobe", 40);
      repeat (19) @(negedge clk);
      check_val("t5_timeout_early", int'(timeout_o), 0);
      repeat (14) @(negedge clk);
      check_val("t5_timeout", int'(timeout_o), 1);
      en_i = 1'b0;
      check_val("t5_to_no_sample", valid_count - vc, 0);
      repeat (20) @(negedge clk);

      // Reset in the middle of WAIT clears everything, including sticky flags.
      start_seg(int'($urandom_range(1, 65535)), int'($urandom_range(0, 255)), 8'h44, 1);
      wait_strobe("t1_strobe", 40);
      repeat (4) @(negedge clk);
      rst_i = 1'b1;
      en_i  = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("t1_in_reset");
      rst_i = 1'b0;
      @(negedge clk);
      check_zero("t1_after_reset");

      // Back in IDLE: a normal conversion runs.
      resp_mode = 0; resp_delay = 5;
      start_seg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)), 8'h66, 1);
      for (int i = 0; i < 4; i++) wait_valid("t1_post_valid", 40);
      stop_seg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global safety net so the run always ends.
   initial begin
      #2000000;
      $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
      $fatal(1);
   end

endmodule
